rec_play_ctrl: RTL and testbench

Transport controller for the audio recorder. It turns debounced key pulses into a recorder state, and it generates SRAM word addresses and read/write strobes at the audio sample rate. It applies the play speed selected on the switches. It sits directly upstream of the seven-segment status display, which consumes `o_state`, `o_addr` and the same `i_sw` bank, and upstream of the SRAM port mux.

---
 rtl/rec_play_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rec_play_ctrl.sv
// Recorder transport controller: key pulses drive the recorder state, and sample ticks
// produce SRAM word addresses plus one-cycle read/write strobes at the selected play speed.
module rec_play_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic              i_sample_tick,
  input  logic [17:0]       i_sw,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sram_we,
  output logic              o_sram_rd,
  output logic [ADDR_W:0]   o_len
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_REC   = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_we, r_rd, w_we_nxt, w_rd_nxt;
  logic              r_fast;
  logic [3:0]        r_n, w_n;
  logic              w_stop, w_rec, w_play;
  logic [3:0]        w_cnt_inc;
  logic              w_adv, w_end;
  logic [ADDR_W:0]   w_step, w_sum;
  logic              w_unused_sw;

  assign w_unused_sw = ^{i_sw[16:9], i_sw[1:0]};

  // Coinciding keys resolve as stop > rec > play.
  assign w_stop = i_key_stop;
  assign w_rec  = i_key_rec & ~i_key_stop;
  assign w_play = i_key_play & ~i_key_stop & ~i_key_rec;

  always_comb begin
    w_n = 4'd1;
    if (i_sw[8])      w_n = 4'd8;
    else if (i_sw[7]) w_n = 4'd7;
    else if (i_sw[6]) w_n = 4'd6;
    else if (i_sw[5]) w_n = 4'd5;
    else if (i_sw[4]) w_n = 4'd4;
    else if (i_sw[3]) w_n = 4'd3;
    else if (i_sw[2]) w_n = 4'd2;
  end

  // Slow mode moves one word only after the N-th read of it; fast mode moves N words per read.
  assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;
  assign w_adv     = r_fast | (w_cnt_inc >= r_n);
  assign w_step    = r_fast ? (ADDR_W+1)'(r_n) : (ADDR_W+1)'(w_adv);
  assign w_sum     = {1'b0, r_addr} + w_step;
  assign w_end     = w_adv & (w_sum >= r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rec) begin
          w_state_nxt = S_REC;
          w_addr_nxt  = '0;
          w_len_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_REC: begin
        // The pending write's address/length update lands before any key is applied.
        if (r_we) begin
          w_len_nxt = r_len + 1'b1;
          if (r_addr == '1) begin
            w_state_nxt = S_HOLD;
            w_addr_nxt  = '0;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
          end
        end
        if (w_stop) begin
          w_state_nxt = (w_len_nxt == '0) ? S_IDLE : S_HOLD;
          w_addr_nxt  = '0;
        end else if (i_sample_tick && !r_we) begin
          w_we_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_rec) begin
          w_state_nxt = S_REC;
          w_addr_nxt  = '0;
          w_len_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (w_play) begin
          w_state_nxt = S_PLAY;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_PLAY: begin
        if (r_rd) begin
          if (w_end) begin
            w_state_nxt = S_HOLD;
            w_addr_nxt  = '0;
            w_cnt_nxt   = '0;
          end else if (w_adv) begin
            w_addr_nxt = w_sum[ADDR_W-1:0];
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc[2:0];
          end
        end
        if (w_stop) begin
          w_state_nxt = S_HOLD;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (w_play) begin
          if (w_state_nxt == S_PLAY) w_state_nxt = S_PAUSE;
        end else if (i_sample_tick && !r_rd) begin
          w_rd_nxt = 1'b1;
        end
      end
      S_PAUSE: begin
        if (w_stop) begin
          w_state_nxt = S_HOLD;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (w_play) begin
          w_state_nxt = S_PLAY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
      r_fast  <= 1'b0;
      r_n     <= 4'd1;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_rd    <= w_rd_nxt;
      if (i_sample_tick) begin
        r_fast <= i_sw[17];
        r_n    <= w_n;
      end
    end
  end

  assign o_state   = r_state;
  assign o_addr    = r_addr;
  assign o_len     = r_len;
  assign o_sram_we = r_we;
  assign o_sram_rd = r_rd;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Scoreboard bench for rec_play_ctrl (ADDR_W=4): expected strobes are queued with the
// stimulus and matched as the DUT emits them; state/addr/len are checked at key points.
module tb_rec_play_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_rec, key_play, key_stop, tick;
  logic [17:0]   sw;
  logic [2:0]    state;
  logic [AW-1:0] addr;
  logic          we, rd;
  logic [AW:0]   len;

  int n_chk = 0;
  int n_err = 0;
  int sb[$];

  rec_play_ctrl #(.ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_rec(key_rec), .i_key_play(key_play),
    .i_key_stop(key_stop), .i_sample_tick(tick), .i_sw(sw), .o_state(state),
    .o_addr(addr), .o_sram_we(we), .o_sram_rd(rd), .o_len(len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Strobe encoding: 256 marks a read, low bits carry the address.
  always @(negedge clk) begin
    if (!rst && (we || rd)) begin
      chk("strobe_excl", int'(we && rd), 0);
      if (sb.size() == 0) chk("unexpected_strobe", (rd ? 256 : 0) + int'(addr), -1);
      else                chk("strobe", (rd ? 256 : 0) + int'(addr), sb.pop_front());
    end
  end

  task automatic key(input bit r, input bit p, input bit s, input bit t);
    @(negedge clk);
    key_rec = r; key_play = p; key_stop = s; tick = t;
    @(negedge clk);
    key_rec = 0; key_play = 0; key_stop = 0; tick = 0;
  endtask

  // Returns at the falling edge of cycle t+2 relative to the tick cycle t.
  task automatic do_tick(input bit push, input bit is_rd, input int a);
    @(negedge clk);
    @(negedge clk);
    if (push) sb.push_back((is_rd ? 256 : 0) + a);
    tick = 1;
    @(negedge clk);
    tick = 0;
    @(negedge clk);
  endtask

  task automatic sb_drained(input string tag);
    @(negedge clk);
    #1;
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; key_rec = 0; key_play = 0; key_stop = 0; tick = 0; sw = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_addr", addr, 0);
    chk("rst_len", len, 0);
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    rst = 0;

    // Record 5 words.
    key(1, 0, 0, 0);
    chk("rec_state", state, 2);
    for (int i = 0; i < 5; i++) do_tick(1, 0, i);
    key(0, 0, 1, 0);
    chk("rec5_state", state, 1);
    chk("rec5_len", len, 5);
    chk("rec5_addr", addr, 0);
    sb_drained("rec5_sb");

    // Fast play, N=2: reads at 0,2,4 then HOLD.
    sw = 18'h20004;
    key(0, 1, 0, 0);
    chk("fast_state", state, 3);
    do_tick(1, 1, 0);
    chk("fast_addr1", addr, 2);
    do_tick(1, 1, 2);
    do_tick(1, 1, 4);
    chk("fast_end_state", state, 1);
    chk("fast_end_addr", addr, 0);
    sb_drained("fast_sb");

    // Slow play, N=3, len=2: 0,0,0,1,1,1 then HOLD.
    key(1, 0, 0, 0);
    do_tick(1, 0, 0);
    do_tick(1, 0, 1);
    key(0, 0, 1, 0);
    chk("len2", len, 2);
    sw = 18'h00008;
    key(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      do_tick(1, 1, i / 3);
      if (i < 5) chk("slow_state", state, 3);
    end
    chk("slow_end_state", state, 1);
    sb_drained("slow_sb");

    // Pause/resume with len=8, fast N=1.
    key(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) do_tick(1, 0, i);
    key(0, 0, 1, 0);
    chk("len8", len, 8);
    sw = 18'h20000;
    key(0, 1, 0, 0);
    do_tick(1, 1, 0);
    do_tick(1, 1, 1);
    key(0, 1, 0, 0);
    chk("pause_state", state, 4);
    chk("pause_addr", addr, 2);
    for (int i = 0; i < 3; i++) do_tick(0, 0, 0);
    chk("paused_addr", addr, 2);
    chk("paused_state", state, 4);
    key(0, 1, 0, 0);
    chk("resume_state", state, 3);
    do_tick(1, 1, 2);
    chk("resume_addr", addr, 3);
    key(0, 0, 1, 0);
    chk("stop_play_state", state, 1);
    chk("stop_play_addr", addr, 0);
    sb_drained("pause_sb");

    // Key priority and coincidences.
    key(1, 0, 1, 0);
    chk("hold_stoprec_state", state, 1);
    chk("hold_stoprec_len", len, 8);
    key(1, 0, 0, 0);
    key(0, 0, 1, 0);
    chk("rec_len0_stop", state, 0);
    key(1, 0, 0, 1);
    chk("rec_tick_state", state, 2);
    repeat (3) @(negedge clk);
    chk("rec_tick_addr", addr, 0);
    chk("rec_tick_len", len, 0);
    key(0, 0, 1, 0);
    chk("rec_tick_stop", state, 0);
    sb_drained("prio_sb");

    // Capacity: 16 writes fill the buffer and drop to HOLD.
    key(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) do_tick(1, 0, i);
    chk("full_state", state, 1);
    chk("full_len", len, 16);
    chk("full_addr", addr, 0);
    do_tick(0, 0, 0);
    chk("after_full_state", state, 1);
    sb_drained("full_sb");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
